mine_game_ctrl: RTL and testbench
=================================

# mine_game_ctrl

Top-level game sequencer for the 6x6 minesweeper datapath. It arms the mine-placement block and waits for that block to report the board ready. It then serves player reveal and flag commands over a valid/ready handshake, computes neighbour mine counts sequentially, and detects win and lose.

## Interface
Parameters:
- ROWS, 6, grid rows (x coordinate range 0..5)
- COLS, 6, grid columns (y coordinate range 0..5)
- MINES, 5, mines placed per game

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a new game from any state
- place_rst  out  1  drives the placer reset; high one cycle in ARM
- play_enable  in  1  placer "board ready"
- cell_mine  in  36  mine map; bit index = x*6+y
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in PLAY
- cmd_op  in  1  0 = reveal, 1 = flag toggle
- cmd_x, cmd_y  in  3 each  cell coordinates
- rsp_valid  out  1  one-cycle response strobe
- rsp_err  out  1  command rejected
- rsp_hit  out  1  revealed a mine
- rsp_count  out  4  neighbour mine count, 0..8
- revealed, flagged  out  36 each  per-cell status
- game_over, win  out  1 each  sticky until start or reset

## Operation
- States: IDLE, ARM, SETUP, PLAY, CHECK, COUNT, RESP, DONE.
- Reset:
  - All outputs 0, state IDLE, revealed and flagged cleared.
- start (any state, including mid-COUNT):
  - Go to ARM next cycle.
  - Clear revealed, flagged, game_over and win.
  - Drop any in-flight command; no rsp_valid is issued for it.
- ARM: place_rst=1 for one cycle, then SETUP.
- SETUP: wait indefinitely until play_enable=1, then PLAY. cell_mine is sampled continuously and is stable from then on.
- PLAY:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op, x, y and idx=x*6+y, then go to CHECK.
- CHECK: evaluate the command.
  - x>=6 or y>=6: err.
  - Reveal of a flagged cell: err.
  - Flag of a revealed cell: err.
  - Flag of any other cell: toggle flagged[idx].
  - Reveal of an already-revealed cell: recompute count, no state change.
  - Reveal of a mine: set revealed[idx], hit=1, game_over=1.
  - Safe reveal: set revealed[idx], go to COUNT.
  - Err, flag and mine-hit cases go straight to RESP.
- COUNT: 8 cycles, one neighbour per cycle, in the order (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1).
  - Off-grid neighbours contribute 0; there is no wrap-around.
  - Arithmetic uses 4-bit signed offsets on 3-bit coordinates; the bounds check runs before the index multiply.
- RESP:
  - rsp_valid=1 with err, hit and count.
  - Win check: popcount(revealed & ~cell_mine)==36-MINES sets win=1 and game_over=1.
  - Next state DONE if game_over, else PLAY.
- DONE: cmd_ready=0, all outputs hold, waits for start.
- rsp_count=0 whenever err or hit is set.

## Timing
- All outputs are registered.
- A command accepted at clock edge T (handshake sampled in PLAY) enters CHECK.
- rsp_valid latency after edge T:
  - Flag, err or mine hit: high in the cycle after T+1 (2-cycle latency).
  - Safe reveal: high in the cycle after T+9 (10-cycle latency).
- cmd_ready drops the cycle after acceptance and is re-asserted in the cycle after RESP. The maximum throughput is one command per 3 cycles.
- revealed, flagged, game_over and win update on the edge leaving CHECK or RESP. They are visible no later than rsp_valid.
- start and rsp_valid in the same cycle: start wins, and the response is still presented for that cycle.
- cmd_valid outside PLAY is ignored; no buffering.

## Structure
- Shared package mine_pkg holds:
  - ROWS, COLS and MINES constants
  - the state enum
  - the OP_REVEAL and OP_FLAG codes
  - function cell_idx(x,y)=x*6+y, shared with the placer
- One sub-module, mine_nbr_count, holds the neighbour step counter, bounds check and 4-bit accumulator. Its ports are go/x/y/cell_mine in and done/count out.

## Test plan
- Reset, start, then hold play_enable=0 for 50 cycles: place_rst pulses once, the FSM stays in SETUP, cmd_ready=0. Raise play_enable: cmd_ready=1 next cycle.
- Use cell_mine with bits {0,7,14,21,28} set for the remaining cases.
  - Reveal (0,1) -> rsp_count=2, revealed[1]=1, latency 10.
  - Reveal (5,5) -> rsp_count=1.
- Flag (2,2), then reveal (2,2) -> first response err=0 with flagged[14]=1; second response err=1 with revealed[14]=0 and no game_over.
- Reveal (0,0) -> rsp_hit=1, game_over=1, win=0, latency 2. A following cmd_valid is never accepted.
- Reveal (6,3) -> rsp_err=1, no status change.
- Reveal all 31 safe cells, with start asserted once mid-COUNT on a second run:
  - Full run: win=1 on the last RESP.
  - Mid-COUNT start: in-flight command dropped, revealed cleared, FSM returns to ARM.

Source files
------------

// File: rtl/mine_pkg.sv
// Shared types, constants and helpers for the 6x6 minesweeper datapath.
package mine_pkg;

  localparam int unsigned ROWS  = 6;
  localparam int unsigned COLS  = 6;
  localparam int unsigned MINES = 5;
  localparam int unsigned CELLS = ROWS * COLS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SETUP,
    ST_PLAY,
    ST_CHECK,
    ST_COUNT,
    ST_RESP,
    ST_DONE
  } state_e;

  localparam logic OP_REVEAL = 1'b0;
  localparam logic OP_FLAG   = 1'b1;

  // Linear cell index, row-major on x; shared with the mine placer.
  function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
    return 6'(6'(x) * 6'(COLS) + 6'(y));
  endfunction

  function automatic logic [5:0] popcount(input logic [CELLS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < CELLS; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mine_nbr_count.sv
// Sequential neighbour mine counter: one neighbour per cycle, neighbour 0 on the go edge.
module mine_nbr_count
  import mine_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [2:0]  x,
  input  logic [2:0]  y,
  input  logic [35:0] cell_mine,
  output logic        done,
  output logic [3:0]  count
);

  // Offsets held as 4-bit two's complement.
  localparam logic [3:0] NEG1 = 4'hF;
  localparam logic [3:0] ZERO = 4'h0;
  localparam logic [3:0] POS1 = 4'h1;

  logic       busy;
  logic [2:0] step;
  logic [3:0] acc;
  logic [2:0] x_q, y_q;

  logic [2:0] cx, cy, sel;
  logic [3:0] dx, dy, nx, ny;
  logic       in_grid, hit;

  // Neighbour select, bounds check, then mine lookup.
  always_comb begin
    cx  = go ? x : x_q;
    cy  = go ? y : y_q;
    sel = go ? 3'd0 : step;
    dx  = ZERO;
    dy  = ZERO;
    case (sel)
      3'd0: begin dx = NEG1; dy = NEG1; end
      3'd1: begin dx = NEG1; dy = ZERO; end
      3'd2: begin dx = NEG1; dy = POS1; end
      3'd3: begin dx = ZERO; dy = NEG1; end
      3'd4: begin dx = ZERO; dy = POS1; end
      3'd5: begin dx = POS1; dy = NEG1; end
      3'd6: begin dx = POS1; dy = ZERO; end
      default: begin dx = POS1; dy = POS1; end
    endcase
    nx = 4'(cx) + dx;
    ny = 4'(cy) + dy;
    // A step below zero wraps to 4'hF, so one unsigned compare covers both edges.
    in_grid = (nx < 4'(ROWS)) && (ny < 4'(COLS));
    hit     = in_grid && cell_mine[cell_idx(nx[2:0], ny[2:0])];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy  <= 1'b0;
      step  <= '0;
      acc   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      done  <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      if (go) begin
        x_q  <= x;
        y_q  <= y;
        step <= 3'd1;
        acc  <= 4'(hit);
        busy <= 1'b1;
      end else if (busy) begin
        step <= step + 3'd1;
        acc  <= acc + 4'(hit);
        if (step == 3'd7) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          count <= acc + 4'(hit);
        end
      end
    end
  end

endmodule

// File: rtl/mine_game_ctrl.sv
// Minesweeper game sequencer: arms the placer, serves reveal/flag commands, detects win/lose.
module mine_game_ctrl #(
  parameter int unsigned ROWS  = mine_pkg::ROWS,
  parameter int unsigned COLS  = mine_pkg::COLS,
  parameter int unsigned MINES = mine_pkg::MINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        place_rst,
  input  logic        play_enable,
  input  logic [35:0] cell_mine,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [2:0]  cmd_x,
  input  logic [2:0]  cmd_y,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic        rsp_hit,
  output logic [3:0]  rsp_count,
  output logic [35:0] revealed,
  output logic [35:0] flagged,
  output logic        game_over,
  output logic        win
);
  import mine_pkg::*;

  localparam int unsigned SAFE = ROWS * COLS - MINES;

  state_e      state, state_d;
  logic        op_q, op_d;
  logic [2:0]  x_q, x_d, y_q, y_d;
  logic [5:0]  idx_q, idx_d;
  logic [35:0] revealed_d, flagged_d;
  logic        game_over_d, win_d;
  logic        rsp_err_d, rsp_hit_d;
  logic [3:0]  rsp_count_d;
  logic        go, nbr_done;
  logic [3:0]  nbr_count;

  mine_nbr_count u_nbr (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .x         (x_q),
    .y         (y_q),
    .cell_mine (cell_mine),
    .done      (nbr_done),
    .count     (nbr_count)
  );

  // Next state, command evaluation and status updates.
  always_comb begin
    state_d     = state;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    idx_d       = idx_q;
    revealed_d  = revealed;
    flagged_d   = flagged;
    game_over_d = game_over;
    win_d       = win;
    rsp_err_d   = rsp_err;
    rsp_hit_d   = rsp_hit;
    rsp_count_d = rsp_count;
    go          = 1'b0;

    case (state)
      ST_IDLE: ;
      ST_ARM:   state_d = ST_SETUP;
      ST_SETUP: if (play_enable) state_d = ST_PLAY;
      ST_PLAY: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          x_d     = cmd_x;
          y_d     = cmd_y;
          idx_d   = cell_idx(cmd_x, cmd_y);
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        rsp_err_d   = 1'b0;
        rsp_hit_d   = 1'b0;
        rsp_count_d = '0;
        state_d     = ST_RESP;
        if (x_q >= 3'(ROWS) || y_q >= 3'(COLS)) begin
          rsp_err_d = 1'b1;
        end else if (op_q == OP_FLAG) begin
          if (revealed[idx_q]) rsp_err_d = 1'b1;
          else                 flagged_d[idx_q] = ~flagged[idx_q];
        end else if (flagged[idx_q]) begin
          rsp_err_d = 1'b1;
        end else if (revealed[idx_q]) begin
          go      = 1'b1;
          state_d = ST_COUNT;
        end else if (cell_mine[idx_q]) begin
          revealed_d[idx_q] = 1'b1;
          rsp_hit_d         = 1'b1;
          game_over_d       = 1'b1;
        end else begin
          revealed_d[idx_q] = 1'b1;
          go                = 1'b1;
          state_d           = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (nbr_done) begin
          rsp_count_d = nbr_count;
          state_d     = ST_RESP;
        end
      end
      ST_RESP:  state_d = game_over ? ST_DONE : ST_PLAY;
      ST_DONE:  ;
      default:  state_d = ST_IDLE;
    endcase

    // Win is judged as the response launches so it is visible with rsp_valid.
    if (state_d == ST_RESP && popcount(revealed_d & ~cell_mine) == 6'(SAFE)) begin
      win_d       = 1'b1;
      game_over_d = 1'b1;
    end

    if (start) begin
      state_d     = ST_ARM;
      revealed_d  = '0;
      flagged_d   = '0;
      game_over_d = 1'b0;
      win_d       = 1'b0;
      go          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_REVEAL;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      revealed  <= '0;
      flagged   <= '0;
      game_over <= 1'b0;
      win       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_count <= '0;
      cmd_ready <= 1'b0;
      place_rst <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      x_q       <= x_d;
      y_q       <= y_d;
      idx_q     <= idx_d;
      revealed  <= revealed_d;
      flagged   <= flagged_d;
      game_over <= game_over_d;
      win       <= win_d;
      rsp_valid <= (state_d == ST_RESP);
      rsp_err   <= rsp_err_d;
      rsp_hit   <= rsp_hit_d;
      rsp_count <= rsp_count_d;
      cmd_ready <= (state_d == ST_PLAY);
      place_rst <= (state_d == ST_ARM);
    end
  end

endmodule

// File: tb/tb_mine_game_ctrl.sv
// Self-checking bench for mine_game_ctrl against a cell-level game model.
module tb_mine_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, play_enable, cmd_valid, cmd_op;
  logic [2:0]  cmd_x, cmd_y;
  logic [35:0] cell_mine;
  logic        place_rst, cmd_ready, rsp_valid, rsp_err, rsp_hit, game_over, win;
  logic [3:0]  rsp_count;
  logic [35:0] revealed, flagged;

  int checks = 0;
  int errors = 0;

  // Game model state, bit index = x*6+y.
  logic [35:0] m_mine, m_rev, m_flg;
  logic        m_over, m_win;

  mine_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .place_rst(place_rst),
    .play_enable(play_enable), .cell_mine(cell_mine),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_hit(rsp_hit), .rsp_count(rsp_count),
    .revealed(revealed), .flagged(flagged), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nbr_mines(input int x, input int y);
    int n = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 6 && y + dy >= 0 && y + dy < 6)
          if (m_mine[(x + dx) * 6 + (y + dy)]) n++;
    return n;
  endfunction

  function automatic int safe_revealed();
    int n = 0;
    for (int i = 0; i < 36; i++) if (m_rev[i] && !m_mine[i]) n++;
    return n;
  endfunction

  task automatic do_start();
    int n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_rev = '0; m_flg = '0; m_over = 1'b0; m_win = 1'b0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check_eq("start_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_cmd(input logic op, input int x, input int y);
    int n = 0, lat, i, exp_lat;
    logic exp_err, exp_hit;
    int exp_cnt;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check_eq("cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = 3'(x); cmd_y = 3'(y);
    @(negedge clk);
    cmd_valid = 1'b0;

    exp_err = 1'b0; exp_hit = 1'b0; exp_cnt = 0; exp_lat = 2;
    if (x >= 6 || y >= 6) begin
      exp_err = 1'b1;
    end else begin
      i = x * 6 + y;
      if (op) begin
        if (m_rev[i]) exp_err = 1'b1;
        else          m_flg[i] = ~m_flg[i];
      end else if (m_flg[i]) begin
        exp_err = 1'b1;
      end else if (m_mine[i] && !m_rev[i]) begin
        m_rev[i] = 1'b1; exp_hit = 1'b1; m_over = 1'b1;
      end else begin
        m_rev[i] = 1'b1; exp_cnt = nbr_mines(x, y); exp_lat = 10;
      end
    end
    if (safe_revealed() == 31) begin m_win = 1'b1; m_over = 1'b1; end

    lat = 1;
    while (!rsp_valid && lat < 30) begin @(negedge clk); lat++; end
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq($sformatf("latency(%0d,%0d,%0d)", op, x, y), 64'(lat), 64'(exp_lat));
    check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
    check_eq("rsp_hit", 64'(rsp_hit), 64'(exp_hit));
    check_eq("rsp_count", 64'(rsp_count), 64'(exp_cnt));
    check_eq("revealed", 64'(revealed), 64'(m_rev));
    check_eq("flagged", 64'(flagged), 64'(m_flg));
    check_eq("game_over", 64'(game_over), 64'(m_over));
    check_eq("win", 64'(win), 64'(m_win));
  endtask

  initial begin
    int pulses, ready_seen, rsp_seen, n;
    int cells[$];
    rst_n = 1'b1; start = 1'b0; play_enable = 1'b0; cmd_valid = 1'b0;
    cmd_op = 1'b0; cmd_x = '0; cmd_y = '0;
    cell_mine = 36'h0;
    m_mine = '0; m_rev = '0; m_flg = '0; m_over = 1'b0; m_win = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("reset_outs", 64'({place_rst, cmd_ready, rsp_valid, rsp_err, rsp_hit, rsp_count,
                                game_over, win}), 64'd0);
    check_eq("reset_revealed", 64'(revealed), 64'd0);
    check_eq("reset_flagged", 64'(flagged), 64'd0);

    // Placer not ready for 50 cycles: exactly one place_rst pulse, never ready.
    for (int k = 0; k < 5; k++) cell_mine[k * 7] = 1'b1;
    m_mine = cell_mine;
    start = 1'b1;
    pulses = 0; ready_seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (place_rst) pulses++;
      if (cmd_ready) ready_seen++;
    end
    check_eq("place_rst_pulses", 64'(pulses), 64'd1);
    check_eq("setup_ready", 64'(ready_seen), 64'd0);
    play_enable = 1'b1;
    @(negedge clk);
    check_eq("ready_after_enable", 64'(cmd_ready), 64'd1);

    // Directed commands on the diagonal mine map.
    do_cmd(1'b0, 0, 1);
    do_cmd(1'b0, 5, 5);
    do_cmd(1'b1, 2, 2);
    do_cmd(1'b0, 2, 2);
    do_cmd(1'b0, 6, 3);
    do_cmd(1'b0, 3, 7);
    do_cmd(1'b0, 0, 1);
    do_cmd(1'b1, 0, 1);
    do_cmd(1'b1, 2, 2);
    do_cmd(1'b0, 0, 0);

    // After a loss, commands are never accepted.
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_x = 3'd1; cmd_y = 3'd0;
    ready_seen = 0; rsp_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready) ready_seen++;
      if (rsp_valid) rsp_seen++;
    end
    cmd_valid = 1'b0;
    check_eq("done_ready", 64'(ready_seen), 64'd0);
    check_eq("done_rsp", 64'(rsp_seen), 64'd0);
    check_eq("done_over", 64'(game_over), 64'd1);

    // Full winning run in shuffled order.
    do_start();
    cells.delete();
    for (int k = 0; k < 36; k++) if (!m_mine[k]) cells.push_back(k);
    for (int k = cells.size() - 1; k > 0; k--) begin
      int j, t;
      j = int'($urandom_range(0, k));
      t = cells[k]; cells[k] = cells[j]; cells[j] = t;
    end
    foreach (cells[k]) do_cmd(1'b0, cells[k] / 6, cells[k] % 6);
    check_eq("win_final", 64'(win), 64'd1);

    // start during COUNT drops the command and clears the board.
    do_start();
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_x = 3'd0; cmd_y = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("abort_arm", 64'(place_rst), 64'd1);
    check_eq("abort_revealed", 64'(revealed), 64'd0);
    rsp_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check_eq("abort_no_rsp", 64'(rsp_seen), 64'd0);
    m_rev = '0; m_flg = '0; m_over = 1'b0; m_win = 1'b0;
    do_cmd(1'b0, 5, 5);

    // Random games with random mine maps and commands.
    for (int g = 0; g < 6; g++) begin
      cell_mine = '0;
      n = 0;
      while (n < 5) begin
        int p;
        p = int'($urandom_range(0, 35));
        if (!cell_mine[p]) begin cell_mine[p] = 1'b1; n++; end
      end
      m_mine = cell_mine;
      do_start();
      for (int c = 0; c < 40 && !m_over; c++)
        do_cmd(($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
